// File: rtl/nios_pio_pkg.sv
// rtl/nios_pio_pkg.sv - shared register offsets and edge-type codes for the Nios PIO blocks
package nios_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - single-bit synchronizer and debouncer with one-cycle rise/fall pulses
module pio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Any sample matching the stable level restarts the count, so short glitches vanish.
    always_comb begin
        accept   = 1'b0;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = accept & sync2_q;
    assign fall_o   = accept & ~sync2_q;

endmodule

// File: rtl/nios_system_key_pio_in.sv
// rtl/nios_system_key_pio_in.sv - Avalon-MM input PIO with debounce, edge capture and IRQ mask
module nios_system_key_pio_in
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             wr_en;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (in_port[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    always_comb begin
        edge_evt = '0;
        if (EDGE_TYPE == EDGE_RISING)       edge_evt = rise;
        else if (EDGE_TYPE == EDGE_FALLING) edge_evt = fall;
        else                                edge_evt = rise | fall;
    end

    assign wr_en = chipselect & ~write_n;

    // Clear is applied before the new event is OR-ed in, so a same-cycle event survives W1C.
    always_comb begin
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_en && address == PIO_ADDR_IRQMASK)
            irq_mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == PIO_ADDR_EDGECAP)
            edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
        edge_capture_d = edge_capture_d | edge_evt;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:          readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= |(edge_capture_q & irq_mask_q);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
